// File: rtl/jzjpcc_mmio_uart_tx_if.sv
// MMIO register pair plus serial line between the jzjpcc core and the UART transmitter.
interface jzjpcc_mmio_uart_tx_if;
   logic [31:0] mmioOutput;  // command word written by the core
   logic [31:0] mmioInput;   // status word read back by the core
   logic        tx;          // serial line, idle high

   // Core side: drives commands, observes status and line
   modport master (
      output mmioOutput,
      input  mmioInput,
      input  tx
   );

   // Transmitter side: consumes commands, drives status and line
   modport slave (
      input  mmioOutput,
      output mmioInput,
      output tx
   );
endinterface

// File: rtl/jzjpcc_mmio_uart_tx.sv
// 8N1 UART transmitter behind a jzjpcc MMIO register pair, with toggle req/ack
// handshake and a one-byte holding buffer in front of the shifter.
module jzjpcc_mmio_uart_tx #(
   parameter int unsigned CLOCKS_PER_BIT = 434
) (
   input  logic                   clock,
   input  logic                   reset,
   jzjpcc_mmio_uart_tx_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_holding, w_holding_nxt;
   logic             r_holding_full, w_holding_full_nxt;
   logic [7:0]       r_shifter, w_shifter_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit_idx, w_bit_idx_nxt;
   logic             r_ack, w_ack_nxt;
   logic             r_tog_q;
   logic             r_overrun, w_overrun_nxt;
   logic             r_tx, w_tx_nxt;
   logic             r_busy;

   logic             w_toggle;
   logic             w_pending;
   logic             w_overrun_set;
   logic             w_unused;

   assign w_toggle      = bus.mmioOutput[8];
   assign w_pending     = (w_toggle != r_ack);
   // A toggle edge arriving while the previous request was still unacknowledged
   assign w_overrun_set = (w_toggle != r_tog_q) && (r_tog_q != r_ack);
   assign w_unused      = ^bus.mmioOutput[31:10];

   // Next-state, handshake and datapath logic
   always_comb begin
      w_state_nxt        = r_state;
      w_holding_nxt      = r_holding;
      w_holding_full_nxt = r_holding_full;
      w_shifter_nxt      = r_shifter;
      w_cnt_nxt          = r_cnt;
      w_bit_idx_nxt      = r_bit_idx;
      w_ack_nxt          = r_ack;
      w_overrun_nxt      = r_overrun;
      w_tx_nxt           = 1'b1;

      // Capture only into an empty slot, judged on pre-edge fullness
      if (w_pending && !r_holding_full) begin
         w_holding_nxt      = bus.mmioOutput[7:0];
         w_holding_full_nxt = 1'b1;
         w_ack_nxt          = w_toggle;
      end

      // Set beats clear when both happen together
      if (w_overrun_set) begin
         w_overrun_nxt = 1'b1;
      end else if (bus.mmioOutput[9]) begin
         w_overrun_nxt = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (r_holding_full) begin
               w_state_nxt        = S_START;
               w_shifter_nxt      = r_holding;
               w_holding_full_nxt = 1'b0;
               w_cnt_nxt          = CNT_MAX;
            end
         end
         S_START: begin
            if (r_cnt == '0) begin
               w_state_nxt   = S_DATA;
               w_bit_idx_nxt = 3'd0;
               w_cnt_nxt     = CNT_MAX;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (r_cnt == '0) begin
               w_shifter_nxt = {1'b0, r_shifter[7:1]};
               w_cnt_nxt     = CNT_MAX;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (r_cnt == '0) begin
               w_cnt_nxt = CNT_MAX;
               if (r_holding_full) begin
                  w_state_nxt        = S_START;
                  w_shifter_nxt      = r_holding;
                  w_holding_full_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Line level follows the state being entered so tx stays registered
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shifter_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_holding      <= 8'd0;
         r_holding_full <= 1'b0;
         r_shifter      <= 8'd0;
         r_cnt          <= '0;
         r_bit_idx      <= 3'd0;
         r_ack          <= 1'b0;
         r_tog_q        <= 1'b0;
         r_overrun      <= 1'b0;
         r_tx           <= 1'b1;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_holding      <= w_holding_nxt;
         r_holding_full <= w_holding_full_nxt;
         r_shifter      <= w_shifter_nxt;
         r_cnt          <= w_cnt_nxt;
         r_bit_idx      <= w_bit_idx_nxt;
         r_ack          <= w_ack_nxt;
         r_tog_q        <= w_toggle;
         r_overrun      <= w_overrun_nxt;
         r_tx           <= w_tx_nxt;
         r_busy         <= (w_state_nxt != S_IDLE);
      end
   end

   assign bus.mmioInput = {28'd0, r_overrun, r_ack, r_holding_full, r_busy};
   assign bus.tx        = r_tx;

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Directed bench for the MMIO UART transmitter at CLOCKS_PER_BIT=4.
module tb_jzjpcc_mmio_uart_tx;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   jzjpcc_mmio_uart_tx_if bus ();

   jzjpcc_mmio_uart_tx #(.CLOCKS_PER_BIT(4)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Watches one full frame starting at its first start-bit cycle
   task automatic watch_frame(input logic [7:0] d);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      for (int i = 0; i < 40; i++) begin
         check("frame_tx", 32'(bus.tx), 32'(f[i/4]));
         check("frame_busy", 32'(bus.mmioInput[0]), 32'd1);
         step();
      end
      check("post_frame_tx", 32'(bus.tx), 32'd1);
      check("post_frame_busy", 32'(bus.mmioInput[0]), 32'd0);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (bus.mmioInput[0] && k < 300) begin
         step();
         k++;
      end
      check("idle_wait", 32'(bus.mmioInput[0]), 32'd0);
   endtask

   logic [19:0] f2;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.mmioOutput = 32'd0;
      #1;
      check("reset_tx", 32'(bus.tx), 32'd1);
      check("reset_status", bus.mmioInput, 32'd0);
      step();
      step();
      rst = 1'b0;

      // Idle line with no toggle activity
      for (int i = 0; i < 100; i++) begin
         check("idle_tx", 32'(bus.tx), 32'd1);
         check("idle_status", bus.mmioInput, 32'd0);
         step();
      end

      // Single byte 0x55
      bus.mmioOutput = 32'h0000_0155;
      check("t1_c0", bus.mmioInput, 32'd0);
      step();
      check("t1_c1", bus.mmioInput, 32'h6);
      step();
      check("t1_c2", bus.mmioInput, 32'h5);
      watch_frame(8'h55);
      check("t1_end", bus.mmioInput, 32'h4);

      // Back-to-back 0xA3 then 0x0F
      bus.mmioOutput = 32'h0000_00A3;
      check("t2_c0", bus.mmioInput, 32'h4);
      step();
      check("t2_c1", bus.mmioInput, 32'h2);
      step();
      check("t2_c2", bus.mmioInput, 32'h1);
      f2 = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
      for (int i = 0; i < 80; i++) begin
         check("b2b_tx", 32'(bus.tx), 32'(f2[i/4]));
         check("b2b_busy", 32'(bus.mmioInput[0]), 32'd1);
         check("b2b_hf", 32'(bus.mmioInput[1]), ((i >= 1) && (i <= 39)) ? 32'd1 : 32'd0);
         if (i == 0) bus.mmioOutput = 32'h0000_010F;
         step();
      end
      check("t2_end", bus.mmioInput, 32'h4);
      check("t2_end_tx", 32'(bus.tx), 32'd1);

      // Overrun with holding full and request pending
      bus.mmioOutput = 32'h0000_0011;
      step();
      check("t3_cap", bus.mmioInput, 32'h2);
      step();
      check("t3_load", bus.mmioInput, 32'h1);
      bus.mmioOutput = 32'h0000_0122;
      step();
      check("t3_hold", bus.mmioInput, 32'h7);
      bus.mmioOutput = 32'h0000_0033;
      step();
      check("t3_blocked", bus.mmioInput, 32'h7);
      bus.mmioOutput = 32'h0000_0133;
      step();
      check("t3_overrun", bus.mmioInput, 32'hF);
      bus.mmioOutput = 32'h0000_0333;
      step();
      check("t3_clear", bus.mmioInput, 32'h7);

      // Set and clear in the same cycle
      bus.mmioOutput = 32'h0000_0044;
      step();
      check("t4_pending", bus.mmioInput, 32'h7);
      bus.mmioOutput = 32'h0000_0344;
      step();
      check("t4_set_wins", bus.mmioInput, 32'hF);
      step();
      check("t4_cleared", bus.mmioInput, 32'h7);
      bus.mmioOutput = 32'h0000_0144;
      wait_idle();
      check("t4_end", bus.mmioInput, 32'h4);

      // Reset in the middle of a frame
      bus.mmioOutput = 32'h0000_0000;
      step();
      step();
      check("t5_start", 32'(bus.tx), 32'd0);
      for (int i = 0; i < 15; i++) step();
      check("t5_pre_reset_tx", 32'(bus.tx), 32'd0);
      check("t5_pre_reset_busy", 32'(bus.mmioInput[0]), 32'd1);
      rst = 1'b1;
      bus.mmioOutput = 32'h0000_015A;
      #1;
      check("t5_async_tx", 32'(bus.tx), 32'd1);
      check("t5_async_status", bus.mmioInput, 32'd0);
      #2;
      rst = 1'b0;
      step();
      check("t5_cap", bus.mmioInput, 32'h6);
      step();
      check("t5_load", bus.mmioInput, 32'h5);
      watch_frame(8'h5A);
      check("t5_end", bus.mmioInput, 32'h4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
